// File: rtl/ika2151_acc_mixer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ika2151_acc_mixer_if                                            |
// | Brief    : Sample-in / PCM-and-serial-out bundle of the R/L mixer.          |
// | Options  : IKA2151_ACC_CLIPCNT_EN adds o_CLIP_CNT                           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface ika2151_acc_mixer_if #(
   parameter int NUM_CH = 2,
   parameter int IN_W   = 14,
   parameter int OUT_W  = 16
);
   logic                    i_SND_VALID;
   logic [IN_W-1:0]         i_SND_DATA;
   logic [NUM_CH-1:0]       i_CH_MASK;
   logic                    i_FRAME_END;
   logic                    i_FLOAT_MODE;
   logic [NUM_CH*OUT_W-1:0] o_PCM;
   logic                    o_PCM_VALID;
   logic                    o_SO;
   logic [2:0]              o_SO_CH;
   logic                    o_SO_LAST;
   logic                    o_OVERRUN;
`ifdef IKA2151_ACC_CLIPCNT_EN
   logic [NUM_CH*8-1:0]     o_CLIP_CNT;
`endif

   modport master (
`ifdef IKA2151_ACC_CLIPCNT_EN
      input  o_CLIP_CNT,
`endif
      output i_SND_VALID, i_SND_DATA, i_CH_MASK, i_FRAME_END, i_FLOAT_MODE,
      input  o_PCM, o_PCM_VALID, o_SO, o_SO_CH, o_SO_LAST, o_OVERRUN
   );

   modport slave (
`ifdef IKA2151_ACC_CLIPCNT_EN
      output o_CLIP_CNT,
`endif
      input  i_SND_VALID, i_SND_DATA, i_CH_MASK, i_FRAME_END, i_FLOAT_MODE,
      output o_PCM, o_PCM_VALID, o_SO, o_SO_CH, o_SO_LAST, o_OVERRUN
   );
endinterface
`default_nettype wire

// File: rtl/ika2151_acc_mixer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ika2151_acc_mixer                                               |
// | Brief    : Masked multi-channel accumulator, saturating PCM latch and       |
// |            LSB-first serialiser (linear or YM3012-style float words).       |
// | Options  : IKA2151_ACC_CLIPCNT_EN adds per-channel clip counters            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ika2151_acc_mixer #(
   parameter int NUM_CH  = 2,
   parameter int IN_W    = 14,
   parameter int ACC_W   = 18,
   parameter int OUT_W   = 16,
   parameter int GAP_CYC = 3
) (
   input  wire logic          i_EMUCLK,
   input  wire logic          i_MRST,
   input  wire logic          i_CEN_n,
   ika2151_acc_mixer_if.slave bus
);

   localparam int c_WW = (OUT_W > 13) ? OUT_W : 13;
   localparam int c_BW = $clog2(c_WW);
   localparam logic [c_BW-1:0] c_LIN_LAST = c_BW'(OUT_W - 1);
   localparam logic [c_BW-1:0] c_FLT_LAST = c_BW'(12);
   localparam logic [3:0]      c_GAP_LAST = 4'(GAP_CYC - 1);
   localparam logic [2:0]      c_CH_LAST  = 3'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   logic                      w_ce;
   logic                      w_fe;
   logic signed [ACC_W-1:0]   w_sext;
   logic [NUM_CH*OUT_W-1:0]   w_sat;
   logic [NUM_CH-1:0]         w_clip;

   logic [NUM_CH*OUT_W-1:0]   r_pcm;
   logic                      r_pcm_valid;
   logic                      r_float;

   state_t                    r_state;
   logic [2:0]                r_ch;
   logic [c_BW-1:0]           r_bit;
   logic [3:0]                r_gap;
   logic                      r_so;
   logic                      r_so_last;
   logic                      r_overrun;

   logic [2:0]                w_nxt_ch;
   logic [c_BW-1:0]           w_bit_inc;
   logic [c_BW-1:0]           w_last_bit;
   logic [OUT_W-1:0]          w_cur_s;
   logic [OUT_W-1:0]          w_nxt_s;
   logic [OUT_W-1:0]          w_fe_s;
   logic [c_WW-1:0]           w_cur_w;
   logic [c_WW-1:0]           w_nxt_w;
   logic [c_WW-1:0]           w_fe_w;

   assign w_ce   = ~i_CEN_n;
   assign w_fe   = bus.i_FRAME_END;
   assign w_sext = ACC_W'($signed(bus.i_SND_DATA));

   // Serial word: linear sample, or {exponent, mantissa} with the mantissa in the low bits.
   function automatic logic [c_WW-1:0] f_word(input logic [OUT_W-1:0] s, input logic flt);
      logic signed [15:0] ss;
      logic signed [15:0] sh;
      logic signed [15:0] sm;
      logic [2:0]         e;
      logic [9:0]         m;
      ss = 16'($signed(s));
      e  = 3'd7;
      for (int k = 7; k >= 1; k--) begin
         sh = ss >>> (k + 8);
         if (sh == $signed({16{ss[15]}}))
            e = 3'(k);
      end
      sm = ss >>> (e - 3'd1);
      m  = sm[9:0];
      if (flt)
         return c_WW'({e, m});
      else
         return c_WW'(s);
   endfunction

   generate
      for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
         logic signed [ACC_W-1:0] r_acc;
         logic signed [ACC_W-1:0] w_sum;
         logic                    w_add;

         assign w_add = bus.i_SND_VALID & bus.i_CH_MASK[n];
         assign w_sum = r_acc + (w_add ? w_sext : {ACC_W{1'b0}});

         if (ACC_W > OUT_W) begin : g_sat
            logic w_fits;
            assign w_fits    = (w_sum[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){w_sum[ACC_W-1]}});
            assign w_clip[n] = ~w_fits;
            assign w_sat[n*OUT_W +: OUT_W] =
               w_fits           ? w_sum[OUT_W-1:0] :
               w_sum[ACC_W-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                  {1'b0, {(OUT_W-1){1'b1}}};
         end else begin : g_ext
            assign w_clip[n] = 1'b0;
            assign w_sat[n*OUT_W +: OUT_W] = OUT_W'(w_sum);
         end

         // The frame-end sample goes straight into the latched sum, so the accumulator restarts at zero.
         always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
            if (i_MRST)
               r_acc <= '0;
            else if (w_ce)
               r_acc <= w_fe ? {ACC_W{1'b0}} : w_sum;
         end
      end
   endgenerate

   always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
      if (i_MRST) begin
         r_pcm       <= '0;
         r_pcm_valid <= 1'b0;
         r_float     <= 1'b0;
      end else if (w_ce) begin
         r_pcm_valid <= w_fe;
         if (w_fe) begin
            r_pcm   <= w_sat;
            r_float <= bus.i_FLOAT_MODE;
         end
      end
   end

   assign w_nxt_ch   = (r_ch == c_CH_LAST) ? 3'd0 : r_ch + 3'd1;
   assign w_bit_inc  = r_bit + 1'b1;
   assign w_last_bit = r_float ? c_FLT_LAST : c_LIN_LAST;
   assign w_cur_s    = r_pcm[int'(r_ch) * OUT_W +: OUT_W];
   assign w_nxt_s    = r_pcm[int'(w_nxt_ch) * OUT_W +: OUT_W];
   assign w_fe_s     = w_sat[OUT_W-1:0];
   assign w_cur_w    = f_word(w_cur_s, r_float);
   assign w_nxt_w    = f_word(w_nxt_s, r_float);
   assign w_fe_w     = f_word(w_fe_s, bus.i_FLOAT_MODE);

   always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
      if (i_MRST) begin
         r_state   <= S_IDLE;
         r_ch      <= 3'd0;
         r_bit     <= '0;
         r_gap     <= 4'd0;
         r_so      <= 1'b0;
         r_so_last <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_ce) begin
         r_overrun <= 1'b0;
         r_so      <= 1'b0;
         r_so_last <= 1'b0;
         if (w_fe) begin
            // New data always wins; any word still in flight is cut short.
            r_overrun <= (r_state != S_IDLE);
            r_state   <= S_SHIFT;
            r_ch      <= 3'd0;
            r_bit     <= '0;
            r_so      <= w_fe_w[0];
         end else begin
            case (r_state)
               S_SHIFT: begin
                  if (r_bit == w_last_bit) begin
                     if (r_ch == c_CH_LAST) begin
                        r_state <= S_IDLE;
                        r_ch    <= 3'd0;
                     end else if (GAP_CYC == 0) begin
                        r_ch  <= w_nxt_ch;
                        r_bit <= '0;
                        r_so  <= w_nxt_w[0];
                     end else begin
                        r_state <= S_GAP;
                        r_gap   <= 4'd0;
                     end
                  end else begin
                     r_bit     <= w_bit_inc;
                     r_so      <= w_cur_w[w_bit_inc];
                     r_so_last <= (w_bit_inc == w_last_bit);
                  end
               end
               S_GAP: begin
                  if (r_gap == c_GAP_LAST) begin
                     r_state <= S_SHIFT;
                     r_ch    <= w_nxt_ch;
                     r_bit   <= '0;
                     r_so    <= w_nxt_w[0];
                  end else begin
                     r_gap <= r_gap + 4'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_PCM       = r_pcm;
   assign bus.o_PCM_VALID = r_pcm_valid;
   assign bus.o_SO        = r_so;
   assign bus.o_SO_CH     = r_ch;
   assign bus.o_SO_LAST   = r_so_last;
   assign bus.o_OVERRUN   = r_overrun;

`ifdef IKA2151_ACC_CLIPCNT_EN
   generate
      for (genvar n = 0; n < NUM_CH; n++) begin : g_clip
         logic [7:0] r_cnt;
         always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
            if (i_MRST)
               r_cnt <= 8'd0;
            else if (w_ce && w_fe) begin
               if (bus.i_FLOAT_MODE && (bus.i_CH_MASK == '0))
                  r_cnt <= 8'd0;
               else if (w_clip[n] && (r_cnt != 8'hFF))
                  r_cnt <= r_cnt + 8'd1;
            end
         end
         assign bus.o_CLIP_CNT[n*8 +: 8] = r_cnt;
      end
   endgenerate
`else
   logic w_unused_clip;
   assign w_unused_clip = ^w_clip;
`endif

endmodule
`default_nettype wire
